reg_bank_mc: RTL and testbench

//  Multi-channel successor to the single enabled register: CHANNELS lanes of WIDTH bits each.

---
 rtl/reg_bank_mc_pkg.sv | 16 +
 rtl/reg_bank_mc_lane.sv | 33 +++
 rtl/reg_bank_mc.sv | 122 ++++++++++++
 tb/tb_reg_bank_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_mc_pkg.sv
// Shared types for the multi-channel register bank: lane opcodes and dump FSM states.
package reg_bank_mc_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    INC   = 2'b10,
    CLEAR = 2'b11
  } reg_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_e;

endpackage

// File: rtl/reg_bank_mc_lane.sv
// One register lane: applies a hold/load/increment/clear opcode when enabled, flags INC roll-over.
module reg_lane
  import reg_bank_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  reg_op_e          op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= en && (op == INC) && (q == '1);
      if (en) begin
        case (op)
          LOAD:    q <= data;
          INC:     q <= q + WIDTH'(1);
          CLEAR:   q <= '0;
          default: q <= q;
        endcase
      end
    end
  end

endmodule

// File: rtl/reg_bank_mc.sv
// Multi-channel register bank with a pipelined single-lane readback port and a lane dump sequencer.
module reg_bank_mc
  import reg_bank_mc_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned CH_W     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                op,
  input  logic [CH_W-1:0]           wr_sel,
  input  logic [WIDTH-1:0]          data,
  input  logic [CH_W-1:0]           rd_sel,
  output logic [WIDTH-1:0]          outa,
  output logic                      outa_valid,
  output logic [CHANNELS*WIDTH-1:0] lanes_q,
  output logic                      wrap,
  input  logic                      dump_req,
  output logic [WIDTH-1:0]          dump_data,
  output logic [CH_W-1:0]           dump_ch,
  output logic                      dump_valid,
  output logic                      dump_last,
  output logic                      busy
);

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(CHANNELS - 1);

  reg_op_e             op_e;
  logic [WIDTH-1:0]    lane_q    [CHANNELS];
  logic [CHANNELS-1:0] lane_wrap;

  assign op_e = reg_op_e'(op);

  // Lane array; an out-of-range wr_sel matches no lane and so writes nothing.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    reg_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (enable && (wr_sel == CH_W'(i))),
      .op    (op_e),
      .data  (data),
      .q     (lane_q[i]),
      .wrap  (lane_wrap[i])
    );
    assign lanes_q[i*WIDTH +: WIDTH] = lane_q[i];
  end

  assign wrap = |lane_wrap;

  // Readback select; out-of-range lanes read as zero.
  logic [WIDTH-1:0] rd_val_c;
  always_comb begin
    rd_val_c = '0;
    if (32'(rd_sel) < CHANNELS) rd_val_c = lane_q[rd_sel];
  end

  logic [WIDTH-1:0] rb_stage [DEPTH];
  logic [DEPTH-1:0] rb_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) rb_stage[i] <= '0;
      rb_valid <= '0;
    end else begin
      rb_stage[0] <= rd_val_c;
      rb_valid[0] <= 1'b1;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        rb_stage[i] <= rb_stage[i-1];
        rb_valid[i] <= rb_valid[i-1];
      end
    end
  end

  assign outa       = rb_stage[DEPTH-1];
  assign outa_valid = rb_valid[DEPTH-1];

  // Dump sequencer: samples lanes before any same-edge write, one lane per cycle.
  dump_state_e     state;
  logic [CH_W-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dump_data  <= '0;
      dump_ch    <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dump_valid <= 1'b0;
          dump_last  <= 1'b0;
          if (dump_req) begin
            state <= DUMP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        DUMP: begin
          dump_valid <= 1'b1;
          dump_data  <= lane_q[idx];
          dump_ch    <= idx;
          if (idx == LAST_IDX) begin
            dump_last <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            dump_last <= 1'b0;
            idx       <= idx + CH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_mc.sv
// Bench for reg_bank_mc: behavioural lane/readback/dump model checked every cycle plus directed literal checks.
module tb_reg_bank_mc;
  import reg_bank_mc_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int DP = 2;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [CW-1:0]   wr_sel = '0;
  logic [W-1:0]    data = '0;
  logic [CW-1:0]   rd_sel = '0;
  logic [W-1:0]    outa;
  logic            outa_valid;
  logic [CH*W-1:0] lanes_q;
  logic            wrap;
  logic            dump_req = 1'b0;
  logic [W-1:0]    dump_data;
  logic [CW-1:0]   dump_ch;
  logic            dump_valid, dump_last, busy;

  // Second instance with a non-power-of-two lane count to reach out-of-range selects.
  logic          d2_enable = 1'b0;
  logic [1:0]    d2_op = 2'b00;
  logic [1:0]    d2_wr_sel = '0;
  logic [W-1:0]  d2_data = '0;
  logic [1:0]    d2_rd_sel = '0;
  logic [W-1:0]  d2_outa;
  logic          d2_outa_valid;
  logic [3*W-1:0] d2_lanes_q;
  logic          d2_wrap;
  logic [W-1:0]  d2_dump_data;
  logic [1:0]    d2_dump_ch;
  logic          d2_dump_valid, d2_dump_last, d2_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_bank_mc #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op(op), .wr_sel(wr_sel), .data(data),
    .rd_sel(rd_sel), .outa(outa), .outa_valid(outa_valid), .lanes_q(lanes_q), .wrap(wrap),
    .dump_req(dump_req), .dump_data(dump_data), .dump_ch(dump_ch), .dump_valid(dump_valid),
    .dump_last(dump_last), .busy(busy)
  );

  reg_bank_mc #(.WIDTH(W), .CHANNELS(3), .DEPTH(1)) dut2 (
    .clk(clk), .reset(reset), .enable(d2_enable), .op(d2_op), .wr_sel(d2_wr_sel), .data(d2_data),
    .rd_sel(d2_rd_sel), .outa(d2_outa), .outa_valid(d2_outa_valid), .lanes_q(d2_lanes_q),
    .wrap(d2_wrap), .dump_req(1'b0), .dump_data(d2_dump_data), .dump_ch(d2_dump_ch),
    .dump_valid(d2_dump_valid), .dump_last(d2_dump_last), .busy(d2_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: lane values, a FIFO of readback samples, and a beat countdown for dumps.
  logic [W-1:0] m_lane [CH] = '{default: '0};
  logic [W-1:0] rb_q [$];
  int           beats_left = 0;
  int           next_ch = 0;
  logic [W-1:0] e_outa = '0, e_ddata = '0;
  logic         e_ovalid = 0, e_wrap = 0, e_dvalid = 0, e_dlast = 0, e_busy = 0;
  int           e_dch = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lane = '{default: '0};
      rb_q.delete();
      beats_left = 0; next_ch = 0;
      e_outa = '0; e_ovalid = 0; e_wrap = 0; e_dvalid = 0; e_dlast = 0; e_busy = 0;
      e_ddata = '0; e_dch = 0;
    end else begin
      rb_q.push_back(int'(rd_sel) < CH ? m_lane[rd_sel] : W'(0));
      if (rb_q.size() > DP) void'(rb_q.pop_front());
      e_ovalid = (rb_q.size() == DP);
      e_outa   = e_ovalid ? rb_q[0] : W'(0);

      if (beats_left > 0) begin
        e_dvalid = 1; e_ddata = m_lane[next_ch]; e_dch = next_ch;
        e_dlast = (beats_left == 1);
        beats_left--; next_ch++;
      end else begin
        e_dvalid = 0; e_dlast = 0;
        if (dump_req) begin beats_left = CH; next_ch = 0; end
      end
      e_busy = (beats_left > 0);

      e_wrap = 0;
      if (enable && int'(wr_sel) < CH) begin
        case (op)
          2'b01: m_lane[wr_sel] = data;
          2'b10: begin
            e_wrap = (m_lane[wr_sel] == {W{1'b1}});
            m_lane[wr_sel] = m_lane[wr_sel] + W'(1);
          end
          2'b11: m_lane[wr_sel] = '0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [CH*W-1:0] flat;
    for (int i = 0; i < CH; i++) flat[i*W +: W] = m_lane[i];
    check("model lanes_q", 64'(lanes_q), 64'(flat));
    check("model wrap", 64'(wrap), 64'(e_wrap));
    check("model outa", 64'(outa), 64'(e_outa));
    check("model outa_valid", 64'(outa_valid), 64'(e_ovalid));
    check("model dump_valid", 64'(dump_valid), 64'(e_dvalid));
    check("model dump_last", 64'(dump_last), 64'(e_dlast));
    check("model busy", 64'(busy), 64'(e_busy));
    if (e_dvalid) begin
      check("model dump_data", 64'(dump_data), 64'(e_ddata));
      check("model dump_ch", 64'(dump_ch), 64'(e_dch));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [1:0] o, input int sel, input logic [W-1:0] d);
    enable = en; op = o; wr_sel = CW'(sel); data = d;
  endtask

  task automatic beat(input string name, input logic [W-1:0] d, input int c, input logic last);
    check({name, " valid"}, 64'(dump_valid), 64'(1));
    check({name, " data"}, 64'(dump_data), 64'(d));
    check({name, " ch"}, 64'(dump_ch), 64'(c));
    check({name, " last"}, 64'(dump_last), 64'(last));
  endtask

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    check("reset lanes_q", 64'(lanes_q), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset outa_valid", 64'(outa_valid), 64'(0));

    // Loads and pipelined readback
    wr(1, 2'b01, 2, 8'hA5); cyc();
    wr(1, 2'b01, 0, 8'h3C); cyc();
    wr(0, 2'b00, 0, 8'h00); rd_sel = 2;
    check("load lanes_q", 64'(lanes_q), 64'h00A5003C);
    cyc();
    check("readback 1 cycle", 64'(outa), 64'(0));
    cyc();
    check("readback 2 cycles", 64'(outa), 64'hA5);
    check("readback valid", 64'(outa_valid), 64'(1));

    // Increment through wrap
    wr(1, 2'b01, 1, 8'hFE); cyc();
    wr(1, 2'b10, 1, 8'h00); cyc();
    check("inc FF", 64'(lanes_q[15:8]), 64'hFF);
    check("inc no wrap", 64'(wrap), 64'(0));
    cyc();
    check("inc 00", 64'(lanes_q[15:8]), 64'h00);
    check("inc wrap", 64'(wrap), 64'(1));
    wr(0, 2'b00, 0, 8'h00); cyc();
    check("wrap pulse ends", 64'(wrap), 64'(0));

    // Dump with a same-edge write on the dumped lane, and a dump_req while busy
    wr(1, 2'b01, 0, 8'h11); cyc();
    wr(1, 2'b01, 1, 8'h22); cyc();
    wr(1, 2'b01, 2, 8'h33); cyc();
    wr(1, 2'b01, 3, 8'h44); cyc();
    wr(0, 2'b00, 0, 8'h00); dump_req = 1; cyc();
    check("dump busy", 64'(busy), 64'(1));
    check("dump first idle beat", 64'(dump_valid), 64'(0));
    dump_req = 0; cyc();
    beat("beat0", 8'h11, 0, 0);
    wr(1, 2'b01, 1, 8'h99); cyc();
    beat("beat1", 8'h22, 1, 0);
    check("write during dump", 64'(lanes_q[15:8]), 64'h99);
    wr(0, 2'b00, 0, 8'h00); dump_req = 1; cyc();
    beat("beat2", 8'h33, 2, 0);
    dump_req = 0; cyc();
    beat("beat3", 8'h44, 3, 1);
    check("dump end busy", 64'(busy), 64'(0));
    cyc();
    check("busy req ignored", 64'(busy), 64'(0));
    check("no extra beat", 64'(dump_valid), 64'(0));

    // Bounds: clear, disabled load
    wr(1, 2'b11, 3, 8'h00); cyc();
    check("clear lane3", 64'(lanes_q), 64'h00339911);
    wr(0, 2'b01, 0, 8'hFF); cyc();
    check("enable0 load", 64'(lanes_q), 64'h00339911);

    // Held dump_req retriggers after a full dump
    wr(0, 2'b00, 0, 8'h00); dump_req = 1; cyc();
    repeat (CH) cyc();
    check("retrig last", 64'(dump_last), 64'(1));
    cyc();
    check("retrig busy", 64'(busy), 64'(1));
    check("retrig gap", 64'(dump_valid), 64'(0));
    cyc();
    beat("retrig beat0", 8'h11, 0, 0);
    dump_req = 0; cyc();

    // Reset in the middle of a dump
    #2 reset = 1'b1;
    #1;
    check("midreset dump_valid", 64'(dump_valid), 64'(0));
    check("midreset dump_last", 64'(dump_last), 64'(0));
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset lanes_q", 64'(lanes_q), 64'(0));
    check("midreset outa", 64'(outa), 64'(0));
    check("midreset outa_valid", 64'(outa_valid), 64'(0));
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("post reset lanes_q", 64'(lanes_q), 64'(0));
    check("post reset dump_last", 64'(dump_last), 64'(0));

    // Out-of-range selects on a 3-lane bank
    d2_enable = 1; d2_op = 2'b01; d2_wr_sel = 3; d2_data = 8'h5A; cyc();
    check("oob write", 64'(d2_lanes_q), 64'(0));
    check("oob no wrap", 64'(d2_wrap), 64'(0));
    d2_wr_sel = 0; d2_data = 8'h77; cyc();
    check("d2 load", 64'(d2_lanes_q), 64'h000077);
    d2_enable = 0; d2_rd_sel = 3; cyc();
    check("oob readback", 64'(d2_outa), 64'(0));
    d2_rd_sel = 0; cyc();
    check("d2 readback", 64'(d2_outa), 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
